// File: rtl/mcp_logic_unit.sv
// Multi-beat bitwise fold unit: folds a stream of operands with AND/OR/XOR/NOR
// and holds the registered result until the consumer takes it.
module mcp_logic_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    logic [1:0]       state;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    function automatic logic [WIDTH-1:0] fold(input logic [1:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            default: r = ~(x | y);
        endcase
        return r;
    endfunction

    // Valid/ready: a beat transfers on a rising edge where valid and ready are
    // both high. in_ready depends on state only; out_* are held in HOLD until
    // out_ready, and the drain edge reopens the input one cycle later.
    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign out_data  = acc;
    assign out_zero  = (acc == '0);
    assign out_count = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            op_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r  <= in_op;
                        acc   <= fold(in_op, in_a, in_b);
                        cnt   <= CNT_W'(1);
                        state <= in_last ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= fold(op_r, acc, in_b);
                        // Beat count saturates rather than wrapping.
                        if (cnt != '1) cnt <= cnt + CNT_W'(1);
                        state <= in_last ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcp_logic_unit.sv
// Directed bench for mcp_logic_unit: default instance plus a CNT_W=2 instance
// for saturation and a WIDTH=1 instance for the single-bit AND case.
module tb_mcp_logic_unit;

    logic clk;
    logic reset;

    // Default instance (WIDTH=32, CNT_W=8)
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_zero;
    logic [31:0] in_a, in_b, out_data;
    logic [1:0]  in_op;
    logic [7:0]  out_count;

    // Saturation instance (WIDTH=32, CNT_W=2)
    logic        s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_zero;
    logic [31:0] s_in_a, s_in_b, s_out_data;
    logic [1:0]  s_in_op;
    logic [1:0]  s_out_count;

    // Single-bit instance (WIDTH=1, CNT_W=8)
    logic       w_in_valid, w_in_ready, w_in_last, w_out_valid, w_out_ready, w_out_zero;
    logic [0:0] w_in_a, w_in_b, w_out_data;
    logic [1:0] w_in_op;
    logic [7:0] w_out_count;

    int passed;
    int total;

    mcp_logic_unit dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_count(out_count)
    );

    mcp_logic_unit #(.WIDTH(32), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
        .in_op(s_in_op), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_zero(s_out_zero), .out_count(s_out_count)
    );

    mcp_logic_unit #(.WIDTH(1), .CNT_W(8)) dut_bit (
        .clk(clk), .reset(reset),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
        .in_op(w_in_op), .in_last(w_in_last),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .out_zero(w_out_zero), .out_count(w_out_count)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic last);
        in_valid = v; in_a = a; in_b = b; in_op = op; in_last = last;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset = 1'b1;
        out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_op = 2'b00; s_in_last = 1'b0;
        s_out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_op = 2'b00; w_in_last = 1'b0;
        w_out_ready = 1'b0;
        // Beat offered during reset must be ignored
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 1'b1);
        step();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_zero", out_zero, 1);
        chk("rst_out_count", out_count, 0);
        reset = 1'b0;
        drive(1'b0, '0, '0, 2'b00, 1'b0);
        step();
        chk("idle_no_valid", out_valid, 0);

        // Single-beat AND
        drive(1'b1, 32'hF0F0_FFFF, 32'h0FF0_00FF, 2'b00, 1'b1);
        step();
        drive(1'b0, '0, '0, 2'b00, 1'b0);
        chk("and1_valid", out_valid, 1);
        chk("and1_data", out_data, 32'h00F0_00FF);
        chk("and1_zero", out_zero, 0);
        chk("and1_count", out_count, 1);
        chk("and1_in_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("and1_drained", out_valid, 0);
        chk("and1_ready_back", in_ready, 1);

        // Three-beat OR, later op and in_a ignored, idle gap in ACCUM
        drive(1'b1, 32'h1, 32'h2, 2'b01, 1'b0);
        step();
        chk("or3_accum_ready", in_ready, 1);
        chk("or3_accum_novalid", out_valid, 0);
        drive(1'b1, 32'hFFFF_0000, 32'h4, 2'b00, 1'b0);
        step();
        drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1);
        step();
        chk("or3_gap_novalid", out_valid, 0);
        chk("or3_gap_count", out_count, 2);
        drive(1'b1, '0, 32'h8, 2'b10, 1'b1);
        step();
        chk("or3_valid", out_valid, 1);
        chk("or3_data", out_data, 32'hF);
        chk("or3_count", out_count, 3);

        // Backpressure: beats offered while held must be ignored
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 32'hF);
            chk("bp_count", out_count, 3);
            chk("bp_in_ready", in_ready, 0);
        end
        drive(1'b0, '0, '0, 2'b00, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_drained", out_valid, 0);
        chk("bp_ready_back", in_ready, 1);

        // XOR to zero
        drive(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10, 1'b1);
        step();
        drive(1'b0, '0, '0, 2'b00, 1'b0);
        chk("xor_data", out_data, 0);
        chk("xor_zero", out_zero, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Two-beat NOR: ~(0F|03)=FFFFFFF0, then ~(FFFFFFF0|1)=0000000E
        drive(1'b1, 32'h0F, 32'h03, 2'b11, 1'b0);
        step();
        drive(1'b1, '0, 32'h1, 2'b00, 1'b1);
        step();
        drive(1'b0, '0, '0, 2'b00, 1'b0);
        chk("nor2_data", out_data, 32'h0000_000E);
        chk("nor2_count", out_count, 2);
        // Reset and drain together: reset wins, state cleared
        out_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b0;
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_count", out_count, 0);

        // Reset mid-transaction
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 2'b00, 1'b0);
        step();
        drive(1'b1, '0, 32'hFFFF_FF00, 2'b00, 1'b0);
        step();
        drive(1'b1, '0, 32'hFFFF_0000, 2'b00, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, '0, '0, 2'b00, 1'b0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count", out_count, 0);
        chk("midrst_data", out_data, 0);
        step();
        chk("midrst_still_idle", out_valid, 0);
        drive(1'b1, '0, '0, 2'b11, 1'b1);
        step();
        drive(1'b0, '0, '0, 2'b00, 1'b0);
        chk("nor1_data", out_data, 32'hFFFF_FFFF);
        chk("nor1_count", out_count, 1);
        chk("nor1_zero", out_zero, 0);

        // Saturation with CNT_W=2: six AND beats
        s_in_valid = 1'b1; s_in_a = 32'hFFFF_FFFF; s_in_b = 32'hFFFF_FFFF; s_in_op = 2'b00;
        for (int i = 0; i < 6; i++) begin
            s_in_last = (i == 5);
            s_in_b = (i == 3) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
            step();
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
        chk("sat_valid", s_out_valid, 1);
        chk("sat_count", s_out_count, 3);
        chk("sat_data", s_out_data, 32'h00FF_FFFF);

        // WIDTH=1 single-beat AND over all operand pairs
        w_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_in_valid = 1'b1; w_in_op = 2'b00; w_in_last = 1'b1;
            w_in_a = 1'((i >> 1) & 1); w_in_b = 1'(i & 1);
            step();
            w_in_valid = 1'b0;
            chk("bit_valid", w_out_valid, 1);
            chk("bit_data", w_out_data, (i == 3) ? 1 : 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mcp_logic_unit.md
MCP_LOGIC_UNIT -- requirements
Module: mcp_logic_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the beat-counter width in bits (legal range 2..16).
REQ-003 The block SHALL use one clock, clk, and a synchronous, active-high reset, reset.
REQ-004 Port list SHALL be:
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  synchronous active-high reset
- in_valid  input  1  input beat offered
- in_ready  output  1  block accepts the beat this cycle
- in_a  input  WIDTH  first operand; used on the first beat only
- in_b  input  WIDTH  second operand; used on every beat
- in_op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR; sampled on the first beat only
- in_last  input  1  final beat of the transaction
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  result
- out_zero  output  1  high when out_data is all zeros
- out_count  output  CNT_W  number of beats folded into out_data

Function
REQ-005 An input handshake SHALL occur on a rising edge where in_valid and in_ready are both high; an output handshake SHALL occur where out_valid and out_ready are both high.
REQ-006 The block SHALL implement three states: IDLE (no transaction open), ACCUM (transaction open), and HOLD (result pending).
REQ-007 In IDLE, a handshake SHALL:
- latch in_op into op_r
- load acc with (in_a op in_b) and load cnt with 1
- go to HOLD if in_last is high, otherwise go to ACCUM
REQ-008 In ACCUM, a handshake SHALL:
- load acc with (acc op_r in_b), ignoring in_a and in_op
- increment cnt, saturating at 2^CNT_W-1
- go to HOLD if in_last is high, otherwise stay in ACCUM
REQ-009 NOR accumulation SHALL be acc_next = ~(acc | in_b). The other operations SHALL be the plain bitwise AND, OR, and XOR.
REQ-010 in_ready SHALL be high in IDLE and ACCUM and low in HOLD. It SHALL be driven from state only and SHALL NOT depend combinationally on in_valid or out_ready.
REQ-011 out_valid SHALL be high exactly in HOLD. out_data SHALL equal acc, out_count SHALL equal cnt, and out_zero SHALL equal (acc == 0).
REQ-012 While out_valid is high and out_ready is low, out_data, out_zero, and out_count SHALL remain stable.
REQ-013 An output handshake SHALL return the block to IDLE. in_ready SHALL go high the following cycle, with no same-cycle pass-through.
REQ-014 Latency: a one-beat transaction accepted at edge N SHALL present out_valid after edge N. An n-beat transaction SHALL present out_valid after the edge accepting its last beat.
REQ-015 in_valid while in_ready is low SHALL have no effect. in_valid low in ACCUM SHALL hold acc and cnt, with no timeout.
REQ-016 When WIDTH=1 and in_op=00 with in_last=1, out_data SHALL equal in_a AND in_b, so the block is a registered drop-in for the single-bit AND gate.
REQ-017 Arithmetic: no carries are generated, and cnt SHALL never wrap.

Reset
REQ-018 With reset high at a rising edge, the block SHALL enter IDLE. It SHALL clear acc, cnt, and op_r to 0, drive out_valid low and in_ready high, and make out_data 0, out_zero 1, and out_count 0.
REQ-019 Reset SHALL take priority over any simultaneous handshake.
REQ-020 Reset asserted in ACCUM or HOLD SHALL discard the partial or pending result with no output handshake.
REQ-021 in_ready SHALL read high during reset, but beats presented while reset is high SHALL be ignored.

Verification
REQ-022 Single beat, WIDTH=32: in_a=0xF0F0_FFFF, in_b=0x0FF0_00FF, op=00, last=1 -> out_data=0x00F0_00FF, out_zero=0, out_count=1, one cycle later.
REQ-023 Three-beat OR: beat 1 with in_a=0x1, in_b=0x2, op=01; beat 2 with in_b=0x4 and op=00 (ignored); beat 3 with in_b=0x8 and last=1 -> out_data=0xF, out_count=3.
REQ-024 Backpressure: hold out_ready=0 for 5 cycles after the result -> out_* stable, in_ready=0 throughout. Then set out_ready=1 -> in_ready=1 next cycle.
REQ-025 XOR to zero: in_a=in_b=0xDEAD_BEEF, op=10, last=1 -> out_data=0, out_zero=1.
REQ-026 Reset mid-transaction: two ACCUM beats, then reset at the third beat -> no out_valid, out_count=0. A new one-beat NOR with in_a=0, in_b=0 -> out_data=0xFFFF_FFFF.
REQ-027 Saturation with CNT_W=2: a 6-beat AND transaction -> out_count=3.
